spi_flash_responder: RTL

SPI-flash responder: a synthesizable SPI mode-0 slave that emulates the subset of a serial NOR flash command set used by the bootloader's SPI master (read, page program, status, write enable, JEDEC ID). It lets the DFU core run against a memory-backed flash model in simulation and on loopback test boards. Its memory port drives a byte-wide, externally supplied RAM. All SPI pins are oversampled in the system clock domain.

---
 rtl/spi_flash_responder_pkg.sv | 36 +++
 rtl/spi_flash_responder_pin_sync.sv | 33 +++
 rtl/spi_flash_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_pkg.sv
// Shared constants for the SPI flash responder: opcodes, FSM encoding and
// status-register bit positions.
package spi_flash_responder_pkg;

  // Serial NOR opcodes understood by the responder
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDID = 8'h9F;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_READ   = 3'd3;
  localparam logic [2:0] ST_PROG   = 3'd4;
  localparam logic [2:0] ST_STATUS = 3'd5;
  localparam logic [2:0] ST_ID     = 3'd6;
  localparam logic [2:0] ST_IGNORE = 3'd7;

  // Status register bit positions
  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

  // Status byte; WIP is always 0 because writes complete instantly
  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] s;
    s         = 8'h00;
    s[SR_WEL] = wel;
    s[SR_WIP] = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/spi_flash_responder_pin_sync.sv
// Two-flop synchronizer with an edge register for one asynchronous SPI pin.
// Level and edge pulses are all taken from the synchronized copies.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1, r_s2, r_s3;

  // Synchronize the pin and keep one extra stage for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave emulating a serial NOR flash subset (READ, PP, RDSR,
// WREN, WRDI, RDID) on top of a byte-wide external RAM.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_csel,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic              busy
);

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;

  spi_pin_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .i_pin(spi_csel),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset_n(reset_n), .i_pin(spi_clk),
    .o_level(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .i_pin(spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

  logic w_unused;
  assign w_unused = &{1'b0, w_sck_lvl, w_mosi_rise, w_mosi_fall};

  logic [2:0]        r_state;
  logic [2:0]        r_bitcnt;
  logic [6:0]        r_shin;
  logic [7:0]        r_shout;
  logic              r_oe;
  logic              r_wel;
  logic              r_wrote;
  logic              r_is_prog;
  logic [1:0]        r_abyte;
  logic [15:0]       r_ahi;
  logic [1:0]        r_id_idx;
  logic              r_rd_en;
  logic              r_rd_pend;
  logic              r_wr_en;
  logic [7:0]        r_wr_data;
  logic [ADDR_W-1:0] r_mem_addr;

  logic [7:0]  w_byte;
  logic [23:0] w_addr24;
  logic        w_byte_done;

  assign w_byte      = {r_shin, w_mosi};
  assign w_addr24    = {r_ahi, w_byte};
  assign w_byte_done = w_sck_rise & ~w_cs_lvl & (r_bitcnt == 3'd7) & (r_state != ST_IDLE);

  // JEDEC ID byte for the given index; past the third byte the bus reads 0xFF
  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd1:    return JEDEC_ID[15:8];
      2'd2:    return JEDEC_ID[7:0];
      default: return 8'hFF;
    endcase
  endfunction

  // Bit counter and MOSI shifter; both held clear while CS is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bitcnt <= 3'd0;
      r_shin   <= 7'd0;
    end else if (w_cs_lvl) begin
      r_bitcnt <= 3'd0;
      r_shin   <= 7'd0;
    end else if (w_sck_rise) begin
      r_bitcnt <= r_bitcnt + 3'd1;
      r_shin   <= {r_shin[5:0], w_mosi};
    end
  end

  // Command FSM, MISO shifter and memory strobes. A CS rise is checked first
  // so that it always beats a byte completing on the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_wel      <= 1'b0;
      r_wrote    <= 1'b0;
      r_is_prog  <= 1'b0;
      r_abyte    <= 2'd0;
      r_ahi      <= 16'd0;
      r_id_idx   <= 2'd0;
      r_shout    <= 8'hFF;
      r_oe       <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= 8'd0;
      r_mem_addr <= '0;
    end else begin
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_pend <= r_rd_en;
      // Advance within the 256-byte page once the write strobe has gone out
      if (r_wr_en) r_mem_addr[7:0] <= r_mem_addr[7:0] + 8'd1;
      // Fetched byte arrives the cycle after the read strobe
      if (r_rd_pend && r_state == ST_READ) r_shout <= mem_rd_data;
      if (w_cs_rise) begin
        r_state <= ST_IDLE;
        r_oe    <= 1'b0;
        r_shout <= 8'hFF;
        r_wrote <= 1'b0;
        if (r_wrote) r_wel <= 1'b0;
      end else if (r_state == ST_IDLE) begin
        if (w_cs_fall) begin
          r_state <= ST_CMD;
          r_abyte <= 2'd0;
        end
      end else begin
        // The falling edge at a byte boundary presents the already-loaded
        // MSB; the other seven falling edges shift.
        if (w_sck_fall) begin
          if (r_bitcnt != 3'd0) r_shout <= {r_shout[6:0], 1'b1};
          else r_oe <= (r_state == ST_READ) || (r_state == ST_STATUS) || (r_state == ST_ID);
        end
        if (w_byte_done) begin
          case (r_state)
            ST_CMD: begin
              case (w_byte)
                OP_READ: begin
                  r_is_prog <= 1'b0;
                  r_state   <= ST_ADDR;
                end
                OP_PP: begin
                  if (r_wel) begin
                    r_is_prog <= 1'b1;
                    r_state   <= ST_ADDR;
                  end else begin
                    r_state <= ST_IGNORE;
                  end
                end
                OP_RDSR: begin
                  r_state <= ST_STATUS;
                  r_shout <= status_byte(r_wel);
                end
                OP_RDID: begin
                  r_state  <= ST_ID;
                  r_shout  <= JEDEC_ID[23:16];
                  r_id_idx <= 2'd1;
                end
                OP_WREN: begin
                  r_wel   <= 1'b1;
                  r_state <= ST_IGNORE;
                end
                OP_WRDI: begin
                  r_wel   <= 1'b0;
                  r_state <= ST_IGNORE;
                end
                default: r_state <= ST_IGNORE;
              endcase
            end
            ST_ADDR: begin
              r_ahi   <= {r_ahi[7:0], w_byte};
              r_abyte <= r_abyte + 2'd1;
              if (r_abyte == 2'd2) begin
                r_mem_addr <= w_addr24[ADDR_W-1:0];
                if (r_is_prog) begin
                  r_state <= ST_PROG;
                end else begin
                  r_rd_en <= 1'b1;
                  r_state <= ST_READ;
                end
              end
            end
            ST_READ: begin
              // Prefetch the next byte while the master clocks the current one
              r_mem_addr <= r_mem_addr + ADDR_W'(1);
              r_rd_en    <= 1'b1;
            end
            ST_PROG: begin
              r_wr_en   <= 1'b1;
              r_wr_data <= w_byte;
              r_wrote   <= 1'b1;
            end
            ST_STATUS: r_shout <= status_byte(r_wel);
            ST_ID: begin
              r_shout <= id_byte(r_id_idx);
              if (r_id_idx != 2'd3) r_id_idx <= r_id_idx + 2'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign spi_miso    = r_shout[7];
  assign spi_miso_oe = r_oe;
  assign mem_addr    = r_mem_addr;
  assign mem_rd_en   = r_rd_en;
  assign mem_wr_en   = r_wr_en;
  assign mem_wr_data = r_wr_data;
  assign busy        = ~w_cs_lvl;

endmodule
